// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin write arbiter with bounded burst lock for one shared N-bit register
module shared_reg_arbiter #(
    parameter int N         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [3:0]     req_valid,
    input  logic [3:0]     req_lock,
    input  logic [4*N-1:0] req_data,
    output logic [3:0]     req_ready,
    input  logic [N-1:0]   reg_Q,
    output logic [N-1:0]   reg_D,
    output logic           locked,
    output logic [1:0]     last_id,
    output logic [15:0]    wr_count
);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t     fsm;
    logic [1:0] ptr, owner, gid;
    logic [3:0] burst_cnt;
    logic       gv;
    always_comb begin
        gv  = 1'b0;
        gid = ptr;
        for (int k = 3; k >= 0; k--) begin
            if (req_valid[ptr + 2'(k)]) begin
                gv  = 1'b1;
                gid = ptr + 2'(k);
            end
        end
        if (fsm == LOCKED) begin
            gv  = req_valid[owner];
            gid = owner;
        end
        if (reset) gv = 1'b0;
    end
    assign req_ready = gv ? 4'b0001 << gid : 4'b0000;
    assign reg_D     = reset ? '0 : gv ? req_data[gid*N +: N] : reg_Q;
    assign locked    = fsm == LOCKED;
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm       <= IDLE;
            ptr       <= 2'd0;
            owner     <= 2'd0;
            burst_cnt <= 4'd0;
            last_id   <= 2'd0;
            wr_count  <= 16'd0;
        end else begin
            if (gv) begin
                last_id  <= gid;
                wr_count <= wr_count + 16'd1;
                ptr      <= gid + 2'd1;
            end
            if (fsm == IDLE) begin
                if (gv && req_lock[gid] && MAX_BURST > 1) begin
                    fsm       <= LOCKED;
                    owner     <= gid;
                    burst_cnt <= 4'd1;
                end
            end else if (gv && req_lock[owner] && ({1'b0, burst_cnt} + 5'd1) != 5'(MAX_BURST)) begin
                burst_cnt <= burst_cnt + 4'd1;
            end else begin
                // owner dropped valid, released the lock, or hit the burst limit
                fsm       <= IDLE;
                burst_cnt <= 4'd0;
            end
        end
    end
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: vector table plus hand sequences, expected register values via a scoreboard queue
module tb_shared_reg_arbiter;
    localparam int N = 8;
    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [3:0]     req_valid = '0, req_lock = '0, req_ready;
    logic [4*N-1:0] req_data;
    logic [N-1:0]   reg_q, reg_d;
    logic           locked;
    logic [1:0]     last_id;
    logic [15:0]    wr_count;
    int checks = 0, errors = 0;
    logic [N-1:0] sbq[$];
    logic [N-1:0] exp_q;
    logic [15:0]  exp_cnt;
    logic [1:0]   exp_last;
    logic [N-1:0] dat[4];
    typedef struct {bit rst; logic [3:0] v; logic [3:0] l; logic [3:0] r; bit lk;} vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;
    always_ff @(posedge clk) reg_q <= reg_d;

    shared_reg_arbiter #(.N(N), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_lock(req_lock),
        .req_data(req_data), .req_ready(req_ready), .reg_Q(reg_q), .reg_D(reg_d),
        .locked(locked), .last_id(last_id), .wr_count(wr_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] idx(input logic [3:0] r);
        return r[1] ? 2'd1 : r[2] ? 2'd2 : r[3] ? 2'd3 : 2'd0;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("ready_in_reset", req_ready, 4'b0000);
        chk("regD_in_reset", reg_d, '0);
        @(posedge clk); #1;
        exp_q = '0; exp_cnt = '0; exp_last = '0;
        chk("regQ_after_reset", reg_q, '0);
        chk("locked_after_reset", locked, 1'b0);
        chk("count_after_reset", wr_count, 16'd0);
        chk("last_after_reset", last_id, 2'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic cyc(input logic [3:0] v, input logic [3:0] l, input logic [3:0] er, input bit elk);
        logic [N-1:0] nd;
        req_valid = v;
        req_lock  = l;
        #1;
        chk("req_ready", req_ready, er);
        nd = (er == 4'b0000) ? exp_q : dat[idx(er)];
        chk("reg_D", reg_d, nd);
        sbq.push_back(nd);
        if (er != 4'b0000) begin
            exp_cnt++;
            exp_last = idx(er);
        end
        @(posedge clk); #1;
        exp_q = sbq.pop_front();
        chk("reg_Q", reg_q, exp_q);
        chk("locked", locked, elk);
        chk("wr_count", wr_count, exp_cnt);
        chk("last_id", last_id, exp_last);
        @(negedge clk);
    endtask

    initial begin
        dat[0] = 8'hAA; dat[1] = 8'h11; dat[2] = 8'h55; dat[3] = 8'h33;
        req_data = {dat[3], dat[2], dat[1], dat[0]};
        // alternating pair, then idle hold
        tbl.push_back('{1, 4'b0101, 4'b0000, 4'b0001, 0});
        tbl.push_back('{0, 4'b0101, 4'b0000, 4'b0100, 0});
        tbl.push_back('{0, 4'b0101, 4'b0000, 4'b0001, 0});
        tbl.push_back('{0, 4'b0101, 4'b0000, 4'b0100, 0});
        for (int i = 0; i < 3; i++) tbl.push_back('{0, 4'b0000, 4'b0000, 4'b0000, 0});
        // locked burst with forced release
        tbl.push_back('{1, 4'b1010, 4'b0010, 4'b0010, 1});
        tbl.push_back('{0, 4'b1010, 4'b0010, 4'b0010, 1});
        tbl.push_back('{0, 4'b1010, 4'b0010, 4'b0010, 1});
        tbl.push_back('{0, 4'b1010, 4'b0010, 4'b0010, 0});
        tbl.push_back('{0, 4'b1010, 4'b0010, 4'b1000, 0});
        tbl.push_back('{0, 4'b1010, 4'b0010, 4'b0010, 1});
        // owner drops valid mid-burst
        tbl.push_back('{1, 4'b1010, 4'b0010, 4'b0010, 1});
        tbl.push_back('{0, 4'b1010, 4'b0010, 4'b0010, 1});
        tbl.push_back('{0, 4'b1000, 4'b0010, 4'b0000, 0});
        tbl.push_back('{0, 4'b1000, 4'b0010, 4'b1000, 0});
        // full rotation
        tbl.push_back('{1, 4'b1111, 4'b0000, 4'b0001, 0});
        tbl.push_back('{0, 4'b1111, 4'b0000, 4'b0010, 0});
        tbl.push_back('{0, 4'b1111, 4'b0000, 4'b0100, 0});
        tbl.push_back('{0, 4'b1111, 4'b0000, 4'b1000, 0});
        tbl.push_back('{0, 4'b1111, 4'b0000, 4'b0001, 0});
        // lock from a non-requester is ignored
        tbl.push_back('{1, 4'b0001, 4'b0010, 4'b0001, 0});
        tbl.push_back('{0, 4'b0000, 4'b1111, 4'b0000, 0});
        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) begin
                req_valid = '0;
                req_lock  = '0;
                do_reset();
            end
            cyc(tbl[i].v, tbl[i].l, tbl[i].r, tbl[i].lk);
        end
        // reset during the second beat of a locked burst
        req_valid = '0; req_lock = '0;
        do_reset();
        cyc(4'b1111, 4'b0001, 4'b0001, 1);
        req_valid = 4'b0001;
        do_reset();
        cyc(4'b1111, 4'b0000, 4'b0001, 0);
        cyc(4'b1111, 4'b0000, 4'b0010, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
